// File: rtl/encoder_16x4_drain.sv
// Accepts a request vector and drains it as a stream of set-bit indices,
// lowest index first, with last-beat flag, zero flag and population count.
module encoder_16x4_drain #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4   // must equal $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero,
    output logic [IDX_W:0]   out_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [IDX_W:0]     count_q, count_d;
    logic               zero_q, zero_d;

    logic [IDX_W:0]     pop_cnt;
    logic [IDX_W-1:0]   low_idx;
    logic [WIDTH-1:0]   rest;
    logic               at_most_one;
    logic               accept;
    logic               xfer;

    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        pop_cnt = '0;
        for (int k = 0; k < WIDTH; k++) begin
            pop_cnt = pop_cnt + (IDX_W+1)'(in[k]);
        end
    end

    // Scanning downward lets the lowest set bit be the final assignment.
    always_comb begin
        low_idx = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (pending_q[k]) begin
                low_idx = IDX_W'(k);
            end
        end
    end

    assign rest        = pending_q & (pending_q - WIDTH'(1));
    assign at_most_one = (rest == '0);
    assign accept      = (state_q == IDLE) && in_valid;
    assign xfer        = (state_q == DRAIN) && out_ready;

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values; the reset is synchronous and wins over in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            zero_q    <= zero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        zero_d    = zero_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = DRAIN;
                    pending_d = in;
                    count_d   = pop_cnt;
                    zero_d    = (in == '0);
                end
            end
            DRAIN: begin
                if (xfer) begin
                    if (at_most_one) begin
                        state_d   = IDLE;
                        pending_d = '0;
                    end else begin
                        pending_d = rest;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend on registers only; nothing here sees in or out_ready.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DRAIN);
        out_idx   = low_idx;
        out_last  = (state_q == DRAIN) && at_most_one;
        out_zero  = (state_q == DRAIN) && zero_q;
        out_count = count_q;
    end

endmodule

// File: tb/tb_encoder_16x4_drain.sv
// Scoreboard bench: expected beats are queued at each accepted vector and
// compared, field by field, on every cycle the block should be presenting one.
module tb_encoder_16x4_drain;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
        logic       zero;
        logic [4:0] count;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        out_zero;
    logic [4:0]  out_count;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];

    encoder_16x4_drain #(.WIDTH(16), .IDX_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_zero  (out_zero),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected beat list for one accepted vector, built from the bits alone.
    task automatic push_vec(input logic [15:0] v);
        int    cnt;
        int    seen;
        beat_t b;
        cnt  = $countones(v);
        seen = 0;
        if (v == 16'h0000) begin
            b = '{idx: 4'd0, last: 1'b1, zero: 1'b1, count: 5'd0};
            exp_q.push_back(b);
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (v[k]) begin
                    seen++;
                    b = '{idx: 4'(k), last: (seen == cnt), zero: 1'b0, count: 5'(cnt)};
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // One clock: check outputs at the falling edge, then update the model.
    task automatic step();
        bit accept;
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
        if (exp_q.size() != 0) begin
            check("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
            check("out_last", 32'(out_last), 32'(exp_q[0].last));
            check("out_zero", 32'(out_zero), 32'(exp_q[0].zero));
            check("out_count", 32'(out_count), 32'(exp_q[0].count));
        end
        accept = in_valid && (exp_q.size() == 0);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (accept) push_vec(in_vec);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        in_vec   = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_vec   = 16'hxxxx;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 16'hFFFF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_vec   = 16'hxxxx;
        step();

        // Single bit, then turnaround.
        send(16'h0001);
        drain(8);
        step();

        // Spread bits on consecutive cycles.
        send(16'h8421);
        drain(16);
        step();

        // Zero vector.
        send(16'h0000);
        drain(8);
        step();

        // Backpressure with busy-time in_valid pulses that must be ignored.
        out_ready = 1'b0;
        send(16'h0006);
        for (int i = 0; i < 3; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            in_vec   = 16'hFFFF;
            step();
        end
        in_valid  = 1'b0;
        in_vec    = 16'hxxxx;
        out_ready = 1'b1;
        drain(8);
        step();

        // Full vector with out_ready toggling every cycle.
        send(16'hFFFF);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            out_ready = i[0];
            step();
        end
        if (exp_q.size() != 0) check("toggle_timeout", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b1;
        step();

        // Reset mid-drain, then a fresh vector.
        send(16'h00F0);
        step();
        step();
        out_ready = 1'b0;
        rst       = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        send(16'h0100);
        drain(8);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
